// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG sampling controller.
package trng_pkg;

   // Controller states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARMUP  = 3'd1,
      COLLECT = 3'd2,
      PRESENT = 3'd3,
      ALARM   = 3'd4
   } ctrl_state_e;

   // Default sizing
   localparam int unsigned DEF_OUT_WIDTH     = 32;
   localparam int unsigned DEF_DIV_WIDTH     = 16;
   localparam int unsigned DEF_WARMUP_CYCLES = 256;
   localparam int unsigned DEF_RCT_CUTOFF    = 32;

endpackage : trng_pkg

// File: rtl/trng_strobe_gen.sv
// Sample-rate prescaler: one-cycle strobe every div+1 cycles while run is set.
// The strobe is registered, so clear/run/div describe the *next* cycle.
module trng_strobe_gen #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic                 clear,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 strobe
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] cnt_n;

   // Next count: restart on clear or when the period terminal is reached
   always_comb begin
      cnt_n = cnt + DIV_WIDTH'(1);
      if (clear || (cnt >= div)) begin
         cnt_n = '0;
      end
   end

   // Count register and registered strobe for the upcoming cycle
   always_ff @(posedge clk) begin
      if (rst_i) begin
         cnt    <= '0;
         strobe <= 1'b0;
      end else begin
         cnt    <= cnt_n;
         strobe <= run && (cnt_n == div);
      end
   end

endmodule : trng_strobe_gen

// File: rtl/trng_sample_ctrl.sv
// TRNG raw-bit sampling sequencer: warm-up discard, word assembly,
// repetition-count health test and valid/ready word hand-off.
module trng_sample_ctrl
   import trng_pkg::*;
#(
   parameter int unsigned OUT_WIDTH     = DEF_OUT_WIDTH,
   parameter int unsigned DIV_WIDTH     = DEF_DIV_WIDTH,
   parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter int unsigned RCT_CUTOFF    = DEF_RCT_CUTOFF
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 raw_bit_i,
   output logic                 sample_en_o,
   output logic [OUT_WIDTH-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 alarm_o,
   output logic                 busy_o
);

   localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);
   localparam int unsigned CNT_W  = $clog2(OUT_WIDTH + 1);
   localparam int unsigned RUN_W  = $clog2(RCT_CUTOFF + 1);

   ctrl_state_e          state, state_n;
   logic [DIV_WIDTH-1:0] div_q, div_n;
   logic [WARM_W-1:0]    warm_cnt, warm_n, warm_inc;
   logic [CNT_W-1:0]     strb_cnt, strb_n, strb_inc;
   logic [CNT_W-1:0]     cap_cnt, capc_n, capc_inc;
   logic [RUN_W-1:0]     run_cnt, run_n, run_inc, bit_run;
   logic                 prev_bit, prev_n;
   logic                 cap_q, cap_n, cap;
   logic [OUT_WIDTH-1:0] shift, shift_n, shift_in;
   logic [OUT_WIDTH-1:0] data_n;
   logic                 valid_n, alarm_n, busy_n;
   logic                 rct_hit;
   logic                 strobe_clear, strobe_run;

   // Prescaler driving the sampling-register enable
   trng_strobe_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_strobe (
      .clk    (clk),
      .rst_i  (rst_i),
      .clear  (strobe_clear),
      .run    (strobe_run),
      .div    (div_n),
      .strobe (sample_en_o)
   );

   // Saturating increments and per-capture RCT evaluation
   always_comb begin
      warm_inc = (warm_cnt == WARM_W'(WARMUP_CYCLES)) ? warm_cnt : warm_cnt + WARM_W'(1);
      strb_inc = (strb_cnt == CNT_W'(OUT_WIDTH)) ? strb_cnt : strb_cnt + CNT_W'(1);
      capc_inc = (cap_cnt == CNT_W'(OUT_WIDTH)) ? cap_cnt : cap_cnt + CNT_W'(1);
      run_inc  = (run_cnt == RUN_W'(RCT_CUTOFF)) ? run_cnt : run_cnt + RUN_W'(1);
      // run_cnt==0 means no previous bit in this word yet
      bit_run  = ((run_cnt != '0) && (raw_bit_i == prev_bit)) ? run_inc : RUN_W'(1);
      rct_hit  = (bit_run == RUN_W'(RCT_CUTOFF));
      shift_in = {shift[OUT_WIDTH-2:0], raw_bit_i};
      cap      = cap_q && (state == COLLECT);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_n = state;
      div_n   = div_q;
      warm_n  = warm_cnt;
      strb_n  = strb_cnt;
      capc_n  = cap_cnt;
      run_n   = run_cnt;
      prev_n  = prev_bit;
      shift_n = shift;
      data_n  = data_o;
      valid_n = valid_o;
      alarm_n = alarm_o;

      case (state)
         IDLE: begin
            if (enable_i) begin
               div_n   = div_i;
               alarm_n = 1'b0;
               warm_n  = '0;
               state_n = WARMUP;
            end
         end
         WARMUP: begin
            if (!enable_i) begin
               state_n = IDLE;
            end else if (sample_en_o) begin
               warm_n = warm_inc;
               if (warm_inc == WARM_W'(WARMUP_CYCLES)) begin
                  state_n = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (sample_en_o) begin
               strb_n = strb_inc;
            end
            if (cap) begin
               prev_n  = raw_bit_i;
               run_n   = bit_run;
               shift_n = shift_in;
               capc_n  = capc_inc;
            end
            // Health failure outranks both abort and word completion
            if (cap && rct_hit) begin
               alarm_n = 1'b1;
               state_n = ALARM;
            end else if (!enable_i) begin
               state_n = IDLE;
            end else if (cap && (capc_inc == CNT_W'(OUT_WIDTH))) begin
               data_n  = shift_in;
               valid_n = 1'b1;
               state_n = PRESENT;
            end
         end
         PRESENT: begin
            if (valid_o && ready_i) begin
               valid_n = 1'b0;
               state_n = enable_i ? COLLECT : IDLE;
            end
         end
         ALARM: begin
            valid_n = 1'b0;
            alarm_n = 1'b1;
            if (!enable_i) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Fresh word and fresh run on every COLLECT entry
      if ((state_n == COLLECT) && (state != COLLECT)) begin
         strb_n  = '0;
         capc_n  = '0;
         run_n   = '0;
         shift_n = '0;
      end

      strobe_clear = (state_n != state);
      strobe_run   = (state_n == WARMUP) ||
                     ((state_n == COLLECT) && (strb_n < CNT_W'(OUT_WIDTH)));
      cap_n        = sample_en_o && (state == COLLECT);
      busy_n       = (state_n != IDLE);
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst_i) begin
         div_q    <= '0;
         warm_cnt <= '0;
         strb_cnt <= '0;
         cap_cnt  <= '0;
         run_cnt  <= '0;
         prev_bit <= 1'b0;
         cap_q    <= 1'b0;
         shift    <= '0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         alarm_o  <= 1'b0;
         busy_o   <= 1'b0;
      end else begin
         div_q    <= div_n;
         warm_cnt <= warm_n;
         strb_cnt <= strb_n;
         cap_cnt  <= capc_n;
         run_cnt  <= run_n;
         prev_bit <= prev_n;
         cap_q    <= cap_n;
         shift    <= shift_n;
         data_o   <= data_n;
         valid_o  <= valid_n;
         alarm_o  <= alarm_n;
         busy_o   <= busy_n;
      end
   end

endmodule : trng_sample_ctrl

// File: tb/tb_trng_sample_ctrl.sv
// Directed self-checking bench for trng_sample_ctrl with an output-word scoreboard.
module tb_trng_sample_ctrl;

   localparam int unsigned OW  = 8;
   localparam int unsigned DW  = 16;
   localparam int unsigned WU  = 4;
   localparam int unsigned RCT = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          enable_i = 1'b0;
   logic [DW-1:0] div_i = '0;
   logic          raw_bit_i = 1'b0;
   logic          sample_en_o;
   logic [OW-1:0] data_o;
   logic          valid_o;
   logic          ready_i = 1'b0;
   logic          alarm_o;
   logic          busy_o;

   int checks   = 0;
   int failures = 0;

   // Entropy source model
   int          idx  = 0;
   int          mode = 0;          // 0 alternating, 1 stuck-at-1, 2 fixed pattern
   logic [15:0] pat  = 16'hD365;   // cyclic runs never exceed 3

   // Expected-word model
   int          m_warm  = 0;
   int          m_nbits = 0;
   logic [OW-1:0] m_word = '0;
   logic [OW-1:0] sb[$];

   always #5 clk = ~clk;

   trng_sample_ctrl #(
      .OUT_WIDTH     (OW),
      .DIV_WIDTH     (DW),
      .WARMUP_CYCLES (WU),
      .RCT_CUTOFF    (RCT)
   ) dut (
      .clk         (clk),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .div_i       (div_i),
      .raw_bit_i   (raw_bit_i),
      .sample_en_o (sample_en_o),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .alarm_o     (alarm_o),
      .busy_o      (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic ent_bit(input int i);
      logic b;
      case (mode)
         0:       b = ~i[0];
         1:       b = 1'b1;
         default: b = pat[i % 16];
      endcase
      return b;
   endfunction

   // Strobe bits after the warm-up count feed the expected word
   task automatic model_bit(input logic b);
      if (m_warm > 0) begin
         m_warm--;
      end else begin
         m_word = {m_word[OW-2:0], b};
         m_nbits++;
         if (m_nbits == OW) begin
            sb.push_back(m_word);
            m_nbits = 0;
         end
      end
   endtask

   task automatic model_start();
      m_warm  = WU;
      m_nbits = 0;
   endtask

   // One clock: score handshakes, advance, then emulate the sampling flop
   task automatic tick();
      logic          se;
      logic          hs;
      logic [OW-1:0] d;
      logic [OW-1:0] e;
      se = sample_en_o;
      hs = valid_o && ready_i;
      d  = data_o;
      if (hs) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("word", 32'(d), 32'(e));
         end
      end
      @(posedge clk);
      #1;
      if (se) begin
         raw_bit_i = ent_bit(idx);
         idx++;
         model_bit(raw_bit_i);
      end
   endtask

   task automatic wait_valid(input int limit);
      int k = 0;
      while (!valid_o && (k < limit)) begin
         tick();
         k++;
      end
      check("wait_valid", 32'(valid_o), 32'd1);
   endtask

   // Expected strobe cycle relative to the enable rise, period d+1
   function automatic logic exp_se(input int c, input int d);
      int p, e, last;
      p    = d + 1;
      e    = WU * p + 1;
      last = e + d + (OW - 1) * p;
      if ((c >= 1) && (c <= WU * p) && ((c % p) == 0)) return 1'b1;
      if ((c >= e + d) && (c <= last) && (((c - e - d) % p) == 0)) return 1'b1;
      return 1'b0;
   endfunction

   // Raise enable from IDLE and check every strobe and the first valid cycle
   task automatic run_timing(input int d);
      int vcyc;
      vcyc     = (WU * (d + 1) + 1) + d + (OW - 1) * (d + 1) + 2;
      div_i    = DW'(d);
      enable_i = 1'b1;
      model_start();
      for (int c = 1; c <= vcyc; c++) begin
         tick();
         if (c == 1) div_i = (d == 0) ? DW'(5) : DW'(0);
         check($sformatf("se_d%0d_c%0d", d, c), 32'(sample_en_o), 32'(exp_se(c, d)));
         check($sformatf("valid_d%0d_c%0d", d, c), 32'(valid_o), 32'(c == vcyc));
      end
   endtask

   initial begin
      logic [OW-1:0] held;
      int k;

      // Reset values
      tick();
      tick();
      check("rst_se", 32'(sample_en_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_alarm", 32'(alarm_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      rst_i = 1'b0;
      tick();
      check("idle_busy", 32'(busy_o), 32'd0);

      // Word assembly, div 0, alternating bits
      mode    = 0;
      ready_i = 1'b1;
      run_timing(0);
      check("first_word", 32'(data_o), 32'hAA);
      mode = 2;
      tick();
      check("resume_se", 32'(sample_en_o), 32'd1);
      check("accepted_valid", 32'(valid_o), 32'd0);

      // Backpressure
      ready_i = 1'b0;
      wait_valid(60);
      for (int i = 0; i < 20; i++) begin
         check("bp_valid", 32'(valid_o), 32'd1);
         check("bp_data", 32'(data_o), (sb.size() > 0) ? 32'(sb[0]) : 32'hFFFF_FFFF);
         check("bp_se", 32'(sample_en_o), 32'd0);
         tick();
      end
      ready_i = 1'b1;
      tick();
      check("bp_accept", 32'(valid_o), 32'd0);

      // Abort after three collected bits
      k = 0;
      while ((m_nbits != 3) && (k < 40)) begin
         tick();
         k++;
      end
      check("abort_reach3", 32'(m_nbits), 32'd3);
      enable_i = 1'b0;
      tick();
      m_nbits = 0;
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_valid", 32'(valid_o), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("abort_quiet_v", 32'(valid_o), 32'd0);
         check("abort_quiet_se", 32'(sample_en_o), 32'd0);
      end

      // Re-enable: full warm-up at div 3; div_i changes mid-run are ignored
      run_timing(3);
      enable_i = 1'b0;
      tick();
      check("present_to_idle", 32'(busy_o), 32'd0);
      check("present_valid", 32'(valid_o), 32'd0);
      m_nbits = 0;

      // Repetition-count failure
      mode     = 1;
      div_i    = '0;
      enable_i = 1'b1;
      model_start();
      for (int c = 1; c <= 14; c++) begin
         tick();
         check($sformatf("rct_alarm_c%0d", c), 32'(alarm_o), 32'(c >= 10));
         check("rct_valid", 32'(valid_o), 32'd0);
         check("rct_busy", 32'(busy_o), 32'd1);
         if (c >= 10) check("rct_se", 32'(sample_en_o), 32'd0);
      end
      enable_i = 1'b0;
      tick();
      m_nbits = 0;
      check("alarm_idle_busy", 32'(busy_o), 32'd0);
      check("alarm_sticky", 32'(alarm_o), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      // Re-enable clears the alarm; then reset while a word is presented
      mode     = 0;
      ready_i  = 1'b0;
      enable_i = 1'b1;
      model_start();
      tick();
      check("reenable_alarm", 32'(alarm_o), 32'd0);
      check("reenable_busy", 32'(busy_o), 32'd1);
      wait_valid(40);
      check("pending_words", 32'(sb.size()), 32'd1);
      rst_i = 1'b1;
      tick();
      check("mid_rst_se", 32'(sample_en_o), 32'd0);
      check("mid_rst_valid", 32'(valid_o), 32'd0);
      check("mid_rst_alarm", 32'(alarm_o), 32'd0);
      check("mid_rst_busy", 32'(busy_o), 32'd0);
      check("mid_rst_data", 32'(data_o), 32'd0);
      sb.delete();
      rst_i    = 1'b0;
      enable_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_trng_sample_ctrl
